// File: rtl/add_sub_digit_serial_if.sv
// Handshake and operand/result bundle for add_sub_digit_serial.
// The master drives the request and operands; the slave (the arithmetic unit) returns status and results.
interface add_sub_digit_serial_if #(
   parameter int WIDTH = 16
);
   logic             start;
   logic             mode;
   logic [WIDTH-1:0] a_in;
   logic [WIDTH-1:0] b_in;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result;
   logic             carry;
   logic             ovf;
   logic             zero;

   modport master (
      output start, mode, a_in, b_in,
      input  busy, done, result, carry, ovf, zero
   );

   modport slave (
      input  start, mode, a_in, b_in,
      output busy, done, result, carry, ovf, zero
   );
endinterface

// File: rtl/add_sub_digit_serial.sv
// Digit-serial adder/subtractor: WIDTH-bit operands, DIGIT bits per clock, LSB digit first.
// Optional macro ADD_SUB_SAT_EN saturates the result on signed overflow.
module add_sub_digit_serial #(
   parameter int WIDTH = 16,
   parameter int DIGIT = 4
) (
   input logic                  clk,
   input logic                  rst,
   add_sub_digit_serial_if.slave bus
);
   localparam int N  = WIDTH / DIGIT;
   localparam int CW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic {IDLE, RUN} state_t;

   state_t           state_q;
   logic [WIDTH-1:0] aShift_q;
   logic [WIDTH-1:0] bShift_q;
   logic [WIDTH-1:0] sumShift_q;
   logic             carryInt_q;
   logic [CW-1:0]    cnt_q;
   logic             aMsb_q;
   logic             bMsb_q;
   logic             busy_q;
   logic             done_q;
   logic [WIDTH-1:0] result_q;
   logic             carry_q;
   logic             ovf_q;
   logic             zero_q;

   logic [DIGIT:0]   digitSum_d;
   logic [WIDTH-1:0] sumShift_d;
   logic             ovf_d;
   logic [WIDTH-1:0] result_d;

   // B is stored pre-inverted for subtraction, so one overflow rule covers both modes.
   always_comb begin
      digitSum_d = {1'b0, aShift_q[DIGIT-1:0]} + {1'b0, bShift_q[DIGIT-1:0]}
                 + {{DIGIT{1'b0}}, carryInt_q};
      sumShift_d = (sumShift_q >> DIGIT)
                 | (WIDTH'(digitSum_d[DIGIT-1:0]) << (WIDTH - DIGIT));
      ovf_d      = (aMsb_q == bMsb_q) && (sumShift_d[WIDTH-1] != aMsb_q);
`ifdef ADD_SUB_SAT_EN
      if (ovf_d) begin
         result_d = aMsb_q ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
      end else begin
         result_d = sumShift_d;
      end
`else
      result_d = sumShift_d;
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         aShift_q   <= '0;
         bShift_q   <= '0;
         sumShift_q <= '0;
         carryInt_q <= 1'b0;
         cnt_q      <= '0;
         aMsb_q     <= 1'b0;
         bMsb_q     <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         result_q   <= '0;
         carry_q    <= 1'b0;
         ovf_q      <= 1'b0;
         zero_q     <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (bus.start) begin
                  aShift_q   <= bus.a_in;
                  bShift_q   <= bus.mode ? ~bus.b_in : bus.b_in;
                  aMsb_q     <= bus.a_in[WIDTH-1];
                  bMsb_q     <= bus.mode ? ~bus.b_in[WIDTH-1] : bus.b_in[WIDTH-1];
                  carryInt_q <= bus.mode;
                  cnt_q      <= '0;
                  busy_q     <= 1'b1;
                  state_q    <= RUN;
               end
            end
            RUN: begin
               aShift_q   <= aShift_q >> DIGIT;
               bShift_q   <= bShift_q >> DIGIT;
               sumShift_q <= sumShift_d;
               carryInt_q <= digitSum_d[DIGIT];
               cnt_q      <= cnt_q + CW'(1);
               // Results are published only here, so partial sums never reach the port.
               if (cnt_q == CW'(N - 1)) begin
                  state_q  <= IDLE;
                  busy_q   <= 1'b0;
                  done_q   <= 1'b1;
                  result_q <= result_d;
                  carry_q  <= digitSum_d[DIGIT];
                  ovf_q    <= ovf_d;
                  zero_q   <= (result_d == '0);
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.busy   = busy_q;
   assign bus.done   = done_q;
   assign bus.result = result_q;
   assign bus.carry  = carry_q;
   assign bus.ovf    = ovf_q;
   assign bus.zero   = zero_q;
endmodule

// File: tb/tb_add_sub_digit_serial.sv
// Self-checking bench for add_sub_digit_serial: a 16/4 instance and a single-pass 4/4 instance,
// compared against an integer-arithmetic reference model.
module tb_add_sub_digit_serial;
   logic clk = 1'b0;
   logic rst;
   int   checks   = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   add_sub_digit_serial_if #(.WIDTH(16)) bus16();
   add_sub_digit_serial_if #(.WIDTH(4))  bus4();

   add_sub_digit_serial #(.WIDTH(16), .DIGIT(4)) dut16 (.clk(clk), .rst(rst), .bus(bus16));
   add_sub_digit_serial #(.WIDTH(4),  .DIGIT(4)) dut4  (.clk(clk), .rst(rst), .bus(bus4));

   // Returns {zero, ovf, carry, result[15:0]} for a w-bit operation using plain signed/unsigned arithmetic.
   function automatic logic [18:0] refModel(input int w, input logic [15:0] a, input logic [15:0] b,
                                            input logic m);
      longint full, mask, ua, ub, sa, sb, ur, sr, maxPos, minNeg;
      logic [15:0] res;
      logic c, o;
      full   = longint'(1) << w;
      mask   = full - 1;
      ua     = longint'(a) & mask;
      ub     = longint'(b) & mask;
      sa     = (ua >= full / 2) ? ua - full : ua;
      sb     = (ub >= full / 2) ? ub - full : ub;
      ur     = m ? ua - ub : ua + ub;
      c      = m ? (ua >= ub) : (ur >= full);
      sr     = m ? sa - sb : sa + sb;
      maxPos = full / 2 - 1;
      minNeg = -(full / 2);
      o      = (sr > maxPos) || (sr < minNeg);
      res    = 16'(ur & mask);
`ifdef ADD_SUB_SAT_EN
      if (o) res = (sr > maxPos) ? 16'(maxPos) : 16'(minNeg & mask);
`endif
      return {res == 16'd0, o, c, res};
   endfunction

   task automatic run16(input logic [15:0] a, input logic [15:0] b, input logic m,
                        input bit holdStart, input string tag);
      logic [18:0] exp;
      exp = refModel(16, a, b, m);
      bus16.a_in  = a;
      bus16.b_in  = b;
      bus16.mode  = m;
      bus16.start = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         @(negedge clk);
         if (!holdStart) bus16.start = 1'b0;
         bus16.a_in = 16'($urandom);
         bus16.b_in = 16'($urandom);
         bus16.mode = 1'($urandom);
         checks++;
         if (bus16.busy !== 1'b1 || bus16.done !== 1'b0) begin
            failures++;
            $display("[TB] FAIL %s busy cycle %0d: busy=%b done=%b, expected busy=1 done=0",
                     tag, i, bus16.busy, bus16.done);
         end
      end
      @(negedge clk);
      if (holdStart) bus16.start = 1'b0;
      checks++;
      if (bus16.done !== 1'b1 || bus16.busy !== 1'b0) begin
         failures++;
         $display("[TB] FAIL %s done cycle: busy=%b done=%b, expected busy=0 done=1",
                  tag, bus16.busy, bus16.done);
      end
      checks++;
      if ({bus16.zero, bus16.ovf, bus16.carry, bus16.result} !== exp) begin
         failures++;
         $display("[TB] FAIL %s outputs: got res=%h c=%b o=%b z=%b, expected res=%h c=%b o=%b z=%b",
                  tag, bus16.result, bus16.carry, bus16.ovf, bus16.zero,
                  exp[15:0], exp[16], exp[17], exp[18]);
      end
   endtask

   task automatic run4(input logic [3:0] a, input logic [3:0] b, input logic m, input string tag);
      logic [18:0] exp;
      exp = refModel(4, {12'd0, a}, {12'd0, b}, m);
      bus4.a_in  = a;
      bus4.b_in  = b;
      bus4.mode  = m;
      bus4.start = 1'b1;
      @(negedge clk);
      bus4.start = 1'b0;
      bus4.a_in  = 4'($urandom);
      bus4.b_in  = 4'($urandom);
      checks++;
      if (bus4.busy !== 1'b1 || bus4.done !== 1'b0) begin
         failures++;
         $display("[TB] FAIL %s busy cycle: busy=%b done=%b, expected busy=1 done=0",
                  tag, bus4.busy, bus4.done);
      end
      @(negedge clk);
      checks++;
      if (bus4.done !== 1'b1 || bus4.busy !== 1'b0) begin
         failures++;
         $display("[TB] FAIL %s done cycle: busy=%b done=%b, expected busy=0 done=1",
                  tag, bus4.busy, bus4.done);
      end
      checks++;
      if ({bus4.zero, bus4.ovf, bus4.carry, bus4.result} !== {exp[18:16], exp[3:0]}) begin
         failures++;
         $display("[TB] FAIL %s outputs: got res=%h c=%b o=%b z=%b, expected res=%h c=%b o=%b z=%b",
                  tag, bus4.result, bus4.carry, bus4.ovf, bus4.zero,
                  exp[3:0], exp[16], exp[17], exp[18]);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus16.start = 1'b0; bus16.mode = 1'b0; bus16.a_in = '0; bus16.b_in = '0;
      bus4.start  = 1'b0; bus4.mode  = 1'b0; bus4.a_in  = '0; bus4.b_in  = '0;
      repeat (2) @(negedge clk);
      checks++;
      if ({bus16.busy, bus16.done, bus16.result, bus16.carry, bus16.ovf, bus16.zero} !== 21'd0) begin
         failures++;
         $display("[TB] FAIL reset16: busy=%b done=%b res=%h c=%b o=%b z=%b, expected all 0",
                  bus16.busy, bus16.done, bus16.result, bus16.carry, bus16.ovf, bus16.zero);
      end
      checks++;
      if ({bus4.busy, bus4.done, bus4.result, bus4.carry, bus4.ovf, bus4.zero} !== 9'd0) begin
         failures++;
         $display("[TB] FAIL reset4: busy=%b done=%b res=%h c=%b o=%b z=%b, expected all 0",
                  bus4.busy, bus4.done, bus4.result, bus4.carry, bus4.ovf, bus4.zero);
      end
      rst = 1'b0;
   endtask

   task automatic test_directed();
      @(negedge clk);
      run16(16'h1234, 16'h0FCD, 1'b0, 1'b0, "add_1234_0fcd");
      checks++;
      if (bus16.result !== 16'h2201 || bus16.carry !== 1'b0) begin
         failures++;
         $display("[TB] FAIL add_literal: got res=%h c=%b, expected res=2201 c=0",
                  bus16.result, bus16.carry);
      end
      @(negedge clk);
      checks++;
      if (bus16.done !== 1'b0) begin
         failures++;
         $display("[TB] FAIL done_pulse_width: done=%b, expected 0", bus16.done);
      end
      run16(16'h0005, 16'h0005, 1'b1, 1'b0, "sub_equal");
      @(negedge clk);
      run16(16'h0005, 16'h0009, 1'b1, 1'b0, "sub_borrow");
      checks++;
      if (bus16.result !== 16'hFFFC || bus16.carry !== 1'b0) begin
         failures++;
         $display("[TB] FAIL sub_borrow_literal: got res=%h c=%b, expected res=fffc c=0",
                  bus16.result, bus16.carry);
      end
      @(negedge clk);
      run16(16'h7000, 16'h2000, 1'b0, 1'b0, "signed_ovf");
      checks++;
`ifdef ADD_SUB_SAT_EN
      if (bus16.result !== 16'h7FFF || bus16.ovf !== 1'b1) begin
         failures++;
         $display("[TB] FAIL ovf_literal: got res=%h o=%b, expected res=7fff o=1", bus16.result, bus16.ovf);
      end
`else
      if (bus16.result !== 16'h9000 || bus16.ovf !== 1'b1) begin
         failures++;
         $display("[TB] FAIL ovf_literal: got res=%h o=%b, expected res=9000 o=1", bus16.result, bus16.ovf);
      end
`endif
   endtask

   task automatic test_random();
      int gap;
      for (int i = 0; i < 30; i++) begin
         gap = int'($urandom_range(0, 2));
         repeat (gap) @(negedge clk);
         run16(16'($urandom), 16'($urandom), 1'($urandom), 1'b0, "random16");
      end
   endtask

   task automatic test_busy_ignore();
      @(negedge clk);
      run16(16'h1111, 16'h2222, 1'b0, 1'b1, "start_held");
      @(negedge clk);
      checks++;
      if (bus16.busy !== 1'b0 || bus16.done !== 1'b0 || bus16.result !== 16'h3333) begin
         failures++;
         $display("[TB] FAIL start_held_after: busy=%b done=%b res=%h, expected busy=0 done=0 res=3333",
                  bus16.busy, bus16.done, bus16.result);
      end
   endtask

   task automatic test_back_to_back();
      @(negedge clk);
      run16(16'h00FF, 16'h0100, 1'b0, 1'b0, "b2b_first");
      run16(16'h0001, 16'h0001, 1'b0, 1'b0, "b2b_second");
      checks++;
      if (bus16.result !== 16'h0002) begin
         failures++;
         $display("[TB] FAIL b2b_literal: got res=%h, expected 0002", bus16.result);
      end
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      bus16.a_in  = 16'h4000;
      bus16.b_in  = 16'h4000;
      bus16.mode  = 1'b0;
      bus16.start = 1'b1;
      @(negedge clk);
      bus16.start = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checks++;
      if ({bus16.busy, bus16.done, bus16.result, bus16.carry, bus16.ovf, bus16.zero} !== 21'd0) begin
         failures++;
         $display("[TB] FAIL reset_mid: busy=%b done=%b res=%h c=%b o=%b z=%b, expected all 0",
                  bus16.busy, bus16.done, bus16.result, bus16.carry, bus16.ovf, bus16.zero);
      end
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         checks++;
         if (bus16.done !== 1'b0 || bus16.busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_mid_quiet cycle %0d: busy=%b done=%b, expected 0 0",
                     i, bus16.busy, bus16.done);
         end
      end
   endtask

   task automatic test_single_pass();
      @(negedge clk);
      run4(4'b1100, 4'b0111, 1'b1, "w4_sub");
      checks++;
`ifdef ADD_SUB_SAT_EN
      if (bus4.result !== 4'b1000 || bus4.carry !== 1'b1) begin
`else
      if (bus4.result !== 4'b0101 || bus4.carry !== 1'b1) begin
`endif
         failures++;
         $display("[TB] FAIL w4_sub_literal: got res=%b c=%b", bus4.result, bus4.carry);
      end
      @(negedge clk);
      run4(4'b0111, 4'b1000, 1'b0, "w4_add");
      checks++;
      if (bus4.result !== 4'b1111 || bus4.carry !== 1'b0 || bus4.ovf !== 1'b0) begin
         failures++;
         $display("[TB] FAIL w4_add_literal: got res=%b c=%b o=%b, expected 1111 0 0",
                  bus4.result, bus4.carry, bus4.ovf);
      end
      for (int i = 0; i < 20; i++) begin
         run4(4'($urandom), 4'($urandom), 1'($urandom), "random4");
      end
   endtask

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_busy_ignore();
      test_back_to_back();
      test_reset_mid();
      test_single_pass();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/add_sub_digit_serial.md
Name: add_sub_digit_serial

Overview:
- Parametrised, multi-cycle, digit-serial adder/subtractor for the arithmetic library.
- Processes a WIDTH-bit operand pair DIGIT bits per clock, LSB digit first, under a start/busy/done handshake.
- Reports unsigned carry/no-borrow, signed overflow and zero flags.
- Used where a full-width ripple adder is too large; the WIDTH=DIGIT instance gives single-pass operation.

Parameters:
- WIDTH, 16: operand and result width in bits; must be a multiple of DIGIT.
- DIGIT, 4: bits processed per RUN cycle; 1 <= DIGIT <= WIDTH.
- N (localparam), WIDTH/DIGIT: number of RUN cycles per operation.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only when busy=0
- mode  input  1  0 = A+B, 1 = A-B; latched with start
- a_in  input  WIDTH  operand A, latched with start
- b_in  input  WIDTH  operand B, latched with start
- busy  output  1  operation in progress
- done  output  1  one-cycle completion pulse
- result  output  WIDTH  sum/difference, held until next completion
- carry  output  1  add: carry-out; sub: 1 = no borrow (A >= B unsigned)
- ovf  output  1  signed two's-complement overflow
- zero  output  1  result == 0

Behaviour:
- Interface: one clock domain, clk. Reset is synchronous and active-high on rst.
- Reset: on a rising edge of clk with rst=1:
  - state goes to IDLE;
  - busy, done, result, carry, ovf and zero all go to 0;
  - the digit counter and internal carry clear.
  - rst takes priority over start.
  - Reset mid-operation aborts the operation; no done pulse is produced.
- FSM states: IDLE and RUN.
- IDLE:
  - start=1 at an edge latches a_in, mode and B' (b_in if mode=0, ~b_in if mode=1).
  - The internal carry is initialised to mode, so subtraction computes A + ~B + 1.
  - The digit counter is set to 0 and the FSM goes to RUN.
- RUN:
  - Each edge adds digit i of A and B' plus the internal carry.
  - The DIGIT-bit sum is stored into the internal shift register; the carry is updated; the counter increments.
  - After digit N-1, the FSM returns to IDLE.
- Timing: with start high in cycle k:
  - busy is high in cycles k+1 .. k+N;
  - done is high only in cycle k+N+1;
  - result, carry, ovf and zero take their new values in cycle k+N+1.
- Outputs update only at completion. Intermediate digits never appear on result.
- Throughput:
  - start is accepted in the same cycle that done is high, so back-to-back operations take N+1 cycles each.
  - start while busy=1 is ignored; operands and mode are not re-latched.
- Operand stability: a_in, b_in and mode may change freely after the start edge.
- carry: final carry-out of the MSB digit. For subtraction, carry=1 means no borrow.
- ovf:
  - add: A[MSB]==B[MSB] and result[MSB]!=A[MSB];
  - sub: A[MSB]!=B[MSB] and result[MSB]!=A[MSB].
- zero: set when the completed result, as driven on the result port, equals 0.
- Wrap-around: without the optional feature, result is the modulo-2^WIDTH value.
- DIGIT=WIDTH: N=1, so done arrives 2 cycles after start.

Optional Feature:
- Macro: ADD_SUB_SAT_EN.
- Defined, when ovf=1 at completion, result saturates:
  - to 0 followed by all-ones (max positive) if A[MSB]=0;
  - to 1 followed by all-zeros (min negative) otherwise.
- Defined, ovf is still reported as 1, and zero is evaluated on the saturated value (always 0).
- carry is unaffected by saturation.
- Not defined: no saturation; result wraps modulo 2^WIDTH.

Test Plan:
- WIDTH=16, DIGIT=4, add: a_in=16'h1234, b_in=16'h0FCD, start pulse in cycle k.
  - busy high in cycles k+1..k+4.
  - done high in cycle k+5 with result=16'h2201, carry=0, ovf=0, zero=0.
- Sub, no borrow: a_in=16'h0005, b_in=16'h0005, mode=1 → result=0, carry=1, zero=1, ovf=0.
- Sub, borrow: a_in=16'h0005, b_in=16'h0009 → result=16'hFFFC, carry=0, ovf=0.
- Signed overflow: add 16'h7000+16'h2000 → ovf=1, result=16'h9000 (wrap), or 16'h7FFF with ADD_SUB_SAT_EN.
- Handshake:
  - start held high during the busy cycles → ignored, result unchanged.
  - new start in the done cycle (16'h0001+16'h0001) → accepted, done 5 cycles later with result=16'h0002.
  - rst asserted in cycle k+2 → busy=0 and all outputs 0 next cycle, no done pulse.
- WIDTH=4, DIGIT=4 instance, mode=1: A=4'b1100, B=4'b0111.
  - done 2 cycles after start with result=4'b0101, carry=1.
  - then A=4'b0111, B=4'b1000, mode=0 → result=4'b1111, carry=0, ovf=0.
